// File: rtl/start_done_fsm_pkg.sv
// Shared types and helpers for the start/done sequencer.
// Optional feature macro used by the top: FSM_AUTO_RESTART_EN.
package start_done_fsm_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Width needed to hold 0..run_cycles, never narrower than one bit.
  function automatic int cnt_width(input int run_cycles);
    int w;
    w = $clog2(run_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/start_done_fsm_run_counter.sv
// Run-phase cycle counter: clears on request, counts while enabled and
// flags the last RUN cycle. It holds at the terminal value instead of wrapping.
module start_done_fsm_run_counter #(
  parameter int RUN_CYCLES = 3,
  parameter int CNT_W      = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(RUN_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/start_done_fsm.sv
// Four-state job sequencer IDLE -> LOAD -> RUN x RUN_CYCLES -> DONE.
// Define FSM_AUTO_RESTART_EN to let a held start chain jobs straight from DONE.
module start_done_fsm #(
  parameter int RUN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  output logic       done,
  output logic [1:0] state_out
);

  import start_done_fsm_pkg::*;

  localparam int CNT_W = cnt_width(RUN_CYCLES);

  state_t state_q;
  state_t state_d;
  logic   run_tc;
  logic   cnt_clr;
  logic   cnt_en;

  // start is a level request accepted only in IDLE; done is a one-cycle
  // completion strobe decoded from the state register, never from inputs.
  assign done      = (state_q == ST_DONE);
  assign state_out = state_q;

  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q != ST_RUN);

  start_done_fsm_run_counter #(
    .RUN_CYCLES (RUN_CYCLES),
    .CNT_W      (CNT_W)
  ) u_run_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (run_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  state_d = run_tc ? ST_DONE : ST_RUN;
      ST_DONE: begin
`ifdef FSM_AUTO_RESTART_EN
        state_d = start ? ST_LOAD : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_start_done_fsm.sv
// Bench for start_done_fsm: two instances (RUN_CYCLES=3 and 1) against a
// job-script reference model; honours FSM_AUTO_RESTART_EN if defined.
module tb_start_done_fsm;

  localparam int RUN_A = 3;
  localparam int RUN_B = 1;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;
`ifdef FSM_AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       done_a, done_b;
  logic [1:0] state_a, state_b;

  int n_checks;
  int n_pass;

  // Reference model: a job is a scripted list of states; an idle machine
  // (or a finishing one with auto-restart) that sees start queues a new job.
  logic [1:0] cur_a, cur_b;
  logic [1:0] exp_q_a[$];
  logic [1:0] exp_q_b[$];

  start_done_fsm #(.RUN_CYCLES(RUN_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .done(done_a), .state_out(state_a)
  );

  start_done_fsm #(.RUN_CYCLES(RUN_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start), .done(done_b), .state_out(state_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    cur_a = S_IDLE;
    cur_b = S_IDLE;
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic model_edge(input logic s);
    if (exp_q_a.size() != 0) begin
      cur_a = exp_q_a.pop_front();
    end else if (s && (cur_a == S_IDLE || (AUTO && cur_a == S_DONE))) begin
      exp_q_a.push_back(S_LOAD);
      for (int i = 0; i < RUN_A; i++) exp_q_a.push_back(S_RUN);
      exp_q_a.push_back(S_DONE);
      cur_a = exp_q_a.pop_front();
    end else begin
      cur_a = S_IDLE;
    end
    if (exp_q_b.size() != 0) begin
      cur_b = exp_q_b.pop_front();
    end else if (s && (cur_b == S_IDLE || (AUTO && cur_b == S_DONE))) begin
      exp_q_b.push_back(S_LOAD);
      for (int i = 0; i < RUN_B; i++) exp_q_b.push_back(S_RUN);
      exp_q_b.push_back(S_DONE);
      cur_b = exp_q_b.pop_front();
    end else begin
      cur_b = S_IDLE;
    end
  endtask

  // driver: present start at the falling edge, advance the model on the
  // rising edge, leave the caller 1 ns after the edge to sample outputs
  task automatic step(input logic s);
    @(negedge clk);
    start = s;
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  function automatic logic [5:0] expected_obs();
    return {cur_a == S_DONE, cur_a, cur_b == S_DONE, cur_b};
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== 6'b0)
        $display("FAIL reset_hold: got %b expected %b", {done_a, state_a, done_b, state_b}, 6'b0);
      else n_pass++;
      #4;
    end
    #(-0) n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== 6'b0)
        $display("FAIL reset_idle_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_single_job();
    int first_done_a;
    int first_done_b;
    first_done_a = -1;
    first_done_b = -1;
    for (int i = 1; i <= 8; i++) begin
      step(i == 1);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL single_edge_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
      if (done_a && first_done_a < 0) first_done_a = i;
      if (done_b && first_done_b < 0) first_done_b = i;
    end
    n_checks++;
    if (first_done_a != RUN_A + 2)
      $display("FAIL latency_a: got edge %0d expected edge %0d", first_done_a, RUN_A + 2);
    else n_pass++;
    n_checks++;
    if (first_done_b != RUN_B + 2)
      $display("FAIL latency_b: got edge %0d expected edge %0d", first_done_b, RUN_B + 2);
    else n_pass++;
  endtask

  task automatic test_held_start();
    int last_done;
    int period;
    period = AUTO ? RUN_A + 2 : RUN_A + 3;
    last_done = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL held_edge_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
      if (done_a) begin
        if (last_done >= 0) begin
          n_checks++;
          if (i - last_done != period)
            $display("FAIL held_period: got %0d expected %0d", i - last_done, period);
          else n_pass++;
        end
        last_done = i;
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL held_drain_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
    end
  endtask

  task automatic test_toggle_during_run();
    int pulses;
    logic s;
    pulses = 0;
    for (int i = 0; i < RUN_A + 6; i++) begin
      if (i == 0) s = 1'b1;
      else if (i <= RUN_A + 1) s = 1'($urandom_range(0, 1));
      else s = 1'b0;
      step(s);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL toggle_edge_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
      if (done_a) pulses++;
    end
    n_checks++;
    if (pulses != 1)
      $display("FAIL toggle_pulses: got %0d expected 1", pulses);
    else n_pass++;
  endtask

  task automatic test_async_reset_mid_run();
    int run_cnt;
    for (int i = 0; i < 3; i++) begin
      step(i == 0);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL arst_pre_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({done_a, state_a, done_b, state_b} !== 6'b0)
      $display("FAIL arst_async: got %b expected %b", {done_a, state_a, done_b, state_b}, 6'b0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({done_a, state_a, done_b, state_b} !== 6'b0)
      $display("FAIL arst_held: got %b expected %b", {done_a, state_a, done_b, state_b}, 6'b0);
    else n_pass++;
    model_reset();
    #2;
    n_rst = 1'b1;
    run_cnt = 0;
    for (int i = 0; i < RUN_A + 5; i++) begin
      step(i == 0);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL arst_post_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
      if (state_a == S_RUN) run_cnt++;
    end
    n_checks++;
    if (run_cnt != RUN_A)
      $display("FAIL arst_run_len: got %0d expected %0d", run_cnt, RUN_A);
    else n_pass++;
  endtask

  task automatic test_random();
    logic s;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      step(s);
      n_checks++;
      if ({done_a, state_a, done_b, state_b} !== expected_obs())
        $display("FAIL random_%0d: got %b expected %b", i, {done_a, state_a, done_b, state_b}, expected_obs());
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_job();
    test_held_start();
    test_toggle_during_run();
    test_async_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
